// File: rtl/cpu_defines_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defines_pkg
// Description : Shared definitions for the 5-stage MIPS core pipeline:
//               reset/write-enable polarities, NOP values and bus widths.
//               Imported by the pipeline registers and their control decode.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_defines_pkg;

    // Bus widths
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    // Polarities and NOP values
    localparam logic                  RstEnable    = 1'b1;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
    localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;

    // Action taken by a pipeline register on the next clock edge.
    typedef enum logic [1:0] {
        PIPE_CLEAR  = 2'd0,
        PIPE_HOLD   = 2'd1,
        PIPE_BUBBLE = 2'd2,
        PIPE_LOAD   = 2'd3
    } pipe_action_e;

endpackage : cpu_defines_pkg
`default_nettype wire

// File: rtl/ex_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_ctrl
// Description : Combinational decode of rst / flush / stall bits into a
//               one-hot pipeline-register action {clear, hold, bubble, load}.
//               Priority: rst > flush > hold > bubble > load. Reusable by any
//               pipeline register: feed it the stall bit of the producing
//               stage (i_stall_cur) and of the consuming stage (i_stall_nxt).
// Ports       : rst          synchronous active-high reset (decoded only)
//               flush        pipeline flush
//               i_stall_cur  stall bit of the stage feeding the register
//               i_stall_nxt  stall bit of the stage reading the register
//               o_clear/o_hold/o_bubble/o_load  one-hot action
// Revision    : 1.0  initial release
// ============================================================================
module ex_mem_ctrl
    import cpu_defines_pkg::*;
(
    input  logic rst,
    input  logic flush,
    input  logic i_stall_cur,
    input  logic i_stall_nxt,
    output logic o_clear,
    output logic o_hold,
    output logic o_bubble,
    output logic o_load
);

    pipe_action_e w_action;

    always_comb begin
        w_action = PIPE_LOAD;
        if (rst == RstEnable || flush) begin
            w_action = PIPE_CLEAR;
        end else if (i_stall_cur && i_stall_nxt) begin
            w_action = PIPE_HOLD;
        end else if (i_stall_cur) begin
            w_action = PIPE_BUBBLE;
        end else begin
            // Producer running: load. A stalled consumer with a running
            // producer cannot be issued by ctrl and is deliberately folded
            // into load here.
            w_action = PIPE_LOAD;
        end
    end

    always_comb begin
        o_clear  = (w_action == PIPE_CLEAR);
        o_hold   = (w_action == PIPE_HOLD);
        o_bubble = (w_action == PIPE_BUBBLE);
        o_load   = (w_action == PIPE_LOAD);
    end

endmodule : ex_mem_ctrl
`default_nettype wire

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_reg
// Description : EX->MEM pipeline register of the 5-stage MIPS core. Captures
//               GPR and HI/LO write results from EX every clock and presents
//               them to MEM one cycle later, with stall hold/bubble and flush.
//               Build option MADD_MSUB_EN: adds storage for the two-cycle
//               MADD/MSUB partial product and cycle count, fed back to EX.
//               Without it hilo_temp_o/cnt_o are constant 0.
// Ports       : clk, rst            clock, synchronous active-high reset
//               stall, flush        global stall vector, pipeline flush
//               ex_*                EX results (wd, wreg, wdata, whilo, hi, lo)
//               hilo_temp_i, cnt_i  EX MADD/MSUB partial product / count
//               mem_*               registered results to MEM
//               hilo_temp_o, cnt_o  previous-cycle partial product / count
// Revision    : 1.0  initial release
// ============================================================================
module ex_mem_reg
    import cpu_defines_pkg::*;
#(
    parameter int DATA_W     = RegBus,
    parameter int REG_ADDR_W = RegAddrBus,
    parameter int STALL_W    = 6,
    parameter int EX_IDX     = 3,
    parameter int MEM_IDX    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [2*DATA_W-1:0]   hilo_temp_i,
    input  logic [1:0]            cnt_i,
    output logic [REG_ADDR_W-1:0] mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [2*DATA_W-1:0]   hilo_temp_o,
    output logic [1:0]            cnt_o
);

    localparam logic [REG_ADDR_W-1:0] C_NOP_ADDR = REG_ADDR_W'(NOPRegAddr);
    localparam logic [DATA_W-1:0]     C_ZERO     = DATA_W'(ZeroWord);

    logic w_clear;
    logic w_hold;
    logic w_bubble;
    logic w_load;

    logic [REG_ADDR_W-1:0] r_mem_wd;
    logic                  r_mem_wreg;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_mem_whilo;
    logic [DATA_W-1:0]     r_mem_hi;
    logic [DATA_W-1:0]     r_mem_lo;

`ifdef MADD_MSUB_EN
    logic [2*DATA_W-1:0]   r_hilo_temp;
    logic [1:0]            r_cnt;
`endif

    // Only the EX and MEM stall bits matter to this register.
    logic w_unused_stall;
    assign w_unused_stall = ^stall;

    ex_mem_ctrl u_ctrl (
        .rst         (rst),
        .flush       (flush),
        .i_stall_cur (stall[EX_IDX]),
        .i_stall_nxt (stall[MEM_IDX]),
        .o_clear     (w_clear),
        .o_hold      (w_hold),
        .o_bubble    (w_bubble),
        .o_load      (w_load)
    );

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_mem_wd    <= C_NOP_ADDR;
            r_mem_wreg  <= WriteDisable;
            r_mem_wdata <= C_ZERO;
            r_mem_whilo <= WriteDisable;
            r_mem_hi    <= C_ZERO;
            r_mem_lo    <= C_ZERO;
`ifdef MADD_MSUB_EN
            // A multicycle op in flight is abandoned.
            r_hilo_temp <= '0;
            r_cnt       <= '0;
`endif
        end else if (w_hold) begin
            // EX and MEM both frozen: every register keeps its value.
        end else if (w_bubble) begin
            // NOP into MEM so no GPR/HI/LO write escapes a stalled EX, while
            // the stalled instruction's MADD/MSUB state is captured for EX.
            r_mem_wd    <= C_NOP_ADDR;
            r_mem_wreg  <= WriteDisable;
            r_mem_wdata <= C_ZERO;
            r_mem_whilo <= WriteDisable;
            r_mem_hi    <= C_ZERO;
            r_mem_lo    <= C_ZERO;
`ifdef MADD_MSUB_EN
            r_hilo_temp <= hilo_temp_i;
            r_cnt       <= cnt_i;
`endif
        end else if (w_load) begin
            r_mem_wd    <= ex_wd;
            r_mem_wreg  <= ex_wreg;
            r_mem_wdata <= ex_wdata;
            r_mem_whilo <= ex_whilo;
            r_mem_hi    <= ex_hi;
            r_mem_lo    <= ex_lo;
`ifdef MADD_MSUB_EN
            // EX moved on: no multicycle op continues into the next cycle.
            r_hilo_temp <= '0;
            r_cnt       <= '0;
`endif
        end
    end

    assign mem_wd    = r_mem_wd;
    assign mem_wreg  = r_mem_wreg;
    assign mem_wdata = r_mem_wdata;
    assign mem_whilo = r_mem_whilo;
    assign mem_hi    = r_mem_hi;
    assign mem_lo    = r_mem_lo;

`ifdef MADD_MSUB_EN
    assign hilo_temp_o = r_hilo_temp;
    assign cnt_o       = r_cnt;
`else
    assign hilo_temp_o = '0;
    assign cnt_o       = '0;

    logic w_unused_madd;
    assign w_unused_madd = ^{hilo_temp_i, cnt_i};
`endif

endmodule : ex_mem_reg
`default_nettype wire
